// File: rtl/i2c_pkg.sv
// i2c_pkg
// Shared definitions for the I2C target: controller state encoding, the
// ACK/NACK bit levels as seen on SDA, and the 7-bit address width.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX,
        ST_RX_ACK,
        ST_TX,
        ST_TX_ACK,
        ST_WAIT_STOP
    } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge
// Brings one asynchronous bus line into the clk domain and reports its
// edges.
//   clk      in   system clock
//   reset    in   synchronous, active-high
//   async_i  in   raw bus level
//   level_o  out  synchronized level
//   rise_o   out  one-cycle pulse on a synchronized 0->1 transition
//   fall_o   out  one-cycle pulse on a synchronized 1->0 transition
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Reset to 1 matches an idle pulled-up bus, so leaving reset on an idle
    // bus produces no edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/i2c_target.sv
// i2c_target
// Single-address I2C target. Oversamples SCL/SDA, decodes START/STOP,
// matches ADDR, then receives bytes (always ACKed) or transmits bytes
// supplied on tx_data until the master NACKs. Never drives SCL; drives SDA
// only as an open-drain pull-low.
//   clk       in   system clock (>= 8x SCL)
//   reset     in   synchronous, active-high
//   scl_i     in   bus SCL level (asynchronous)
//   sda_i     in   bus SDA level (asynchronous)
//   sda_oe    out  1 = pull SDA low, 0 = release
//   rx_data   out  last byte written by the master
//   rx_valid  out  one-cycle pulse when rx_data updates
//   tx_data   in   next byte to transmit, sampled while tx_load = 1
//   tx_load   out  one-cycle pulse; tx_data is latched in that cycle
//   busy      out  1 while addressed
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] ADDR        = 7'h42,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       busy
);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;
    logic start, stop;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (scl_i),
        .level_o (scl_level),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (sda_i),
        .level_o (sda_level),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    // The current (not previous) SCL level qualifies START/STOP, so both
    // lines dropping together out of reset is not mistaken for a START.
    assign start = sda_fall & scl_level;
    assign stop  = sda_rise & scl_level;

    i2c_tgt_state_t state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     shift_in;
    logic           rw_q, rw_d;
    logic           flag_q, flag_d;
    logic           sda_oe_q, sda_oe_d;
    logic [7:0]     rx_data_q, rx_data_d;
    logic           rx_valid_q, rx_valid_d;
    logic           busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            rw_q       <= 1'b0;
            flag_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            flag_q     <= flag_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
        end
    end

    // flag_q is a one-bit "pending" marker reused per state: in ADDR/RX it
    // means eight bits are in and the ACK slot starts on the next scl_fall;
    // in TX_ACK it means the master ACKed and the next byte loads on the
    // next scl_fall. The 3-bit counter wraps to 0 at each byte, so it alone
    // cannot tell "byte complete" from "byte not started".
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        flag_d     = flag_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        busy_d     = busy_q;
        tx_load    = 1'b0;
        shift_in   = {shift_q[6:0], sda_level};

        if (start) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd0;
            flag_d    = 1'b0;
            sda_oe_d  = 1'b0;
        end else if (stop) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            flag_d    = 1'b0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise && !flag_q) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (shift_in[7:1] == ADDR) begin
                                rw_d   = shift_in[0];
                                flag_d = 1'b1;
                            end else begin
                                state_d = ST_WAIT_STOP;
                                busy_d  = 1'b0;
                            end
                        end
                    end else if (scl_fall && flag_q) begin
                        flag_d   = 1'b0;
                        sda_oe_d = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = ST_ADDR_ACK;
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 3'd0;
                        if (rw_q == 1'b0) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RX;
                        end else begin
                            tx_load  = 1'b1;
                            shift_d  = tx_data;
                            sda_oe_d = ~tx_data[7];
                            state_d  = ST_TX;
                        end
                    end
                end

                ST_RX: begin
                    if (scl_rise && !flag_q) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = shift_in;
                            rx_valid_d = 1'b1;
                            flag_d     = 1'b1;
                        end
                    end else if (scl_fall && flag_q) begin
                        flag_d   = 1'b0;
                        sda_oe_d = 1'b1;
                        state_d  = ST_RX_ACK;
                    end
                end

                ST_RX_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_RX;
                    end
                end

                // The bit on the wire is always shift_q[7]; each scl_fall
                // shifts the next one up.
                ST_TX: begin
                    if (scl_fall) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_TX_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end

                ST_TX_ACK: begin
                    if (scl_rise && !flag_q) begin
                        if (sda_level == I2C_ACK) begin
                            flag_d = 1'b1;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end else if (scl_fall && flag_q) begin
                        flag_d    = 1'b0;
                        bit_cnt_d = 3'd0;
                        tx_load   = 1'b1;
                        shift_d   = tx_data;
                        sda_oe_d  = ~tx_data[7];
                        state_d   = ST_TX;
                    end
                end

                default: begin
                end
            endcase
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target
// Bit-level I2C master driving i2c_target over a wired-AND SDA. Expected
// received bytes and tx_load events go into queues as transactions are
// issued; a monitor pops them whenever the target pulses rx_valid/tx_load.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam logic [6:0] TGT_ADDR     = 7'h42;
    localparam int         Q            = 4;
    localparam int         KIND_WRITE   = 0;
    localparam int         KIND_READ    = 1;
    localparam int         KIND_PARTIAL = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       master_scl = 1'b1;
    logic       master_sda = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data_drv;
    logic       tx_load;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_rx_q[$];
    int         exp_tx_q[$];
    logic       oe_allowed;
    logic [7:0] payload[16];

    always #5 clk = ~clk;

    assign sda_bus = master_sda & ~sda_oe;

    i2c_target #(.ADDR(TGT_ADDR), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .scl_i    (master_scl),
        .sda_i    (sda_bus),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data_drv),
        .tx_load  (tx_load),
        .busy     (busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid) begin
                checkOutput("rx_valid_expected", exp_rx_q.size() > 0, 1);
                if (exp_rx_q.size() > 0) checkOutput("rx_data", rx_data, exp_rx_q.pop_front());
            end
            if (tx_load) begin
                checkOutput("tx_load_expected", exp_tx_q.size() > 0, 1);
                if (exp_tx_q.size() > 0) void'(exp_tx_q.pop_front());
            end
            if (sda_oe && !oe_allowed) checkOutput("sda_oe_quiet", sda_oe, 0);
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_start();
        wait_clks(Q); master_sda = 1'b1;
        wait_clks(Q); master_scl = 1'b1;
        wait_clks(Q); master_sda = 1'b0;
        wait_clks(Q); master_scl = 1'b0;
    endtask

    task automatic send_stop();
        wait_clks(Q); master_sda = 1'b0;
        wait_clks(Q); master_scl = 1'b1;
        wait_clks(Q); master_sda = 1'b1;
        wait_clks(Q);
    endtask

    task automatic send_bit(input logic b);
        wait_clks(Q); master_sda = b;
        wait_clks(Q); master_scl = 1'b1;
        wait_clks(2 * Q); master_scl = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        wait_clks(Q); master_sda = 1'b1;
        wait_clks(Q); master_scl = 1'b1;
        wait_clks(Q); b = sda_bus;
        wait_clks(Q); master_scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] data, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(data[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] data);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            data[i] = b;
        end
    endtask

    // One transaction up to (not including) STOP. Expectations come from the
    // protocol rules: only ADDR is acknowledged, every written byte is ACKed
    // and delivered once, a read returns tx bytes in order, one load per byte.
    task automatic applyStimulus(input int kind, input logic [6:0] addr, input int n);
        logic       ack;
        logic [7:0] got;
        logic       matched;
        logic       rw;
        logic [7:0] first;
        matched    = (addr == TGT_ADDR);
        rw         = (kind == KIND_READ);
        first      = payload[0];
        oe_allowed = matched;
        if (rw && matched) begin
            tx_data_drv = payload[0];
            exp_tx_q.push_back(0);
        end
        send_start();
        send_byte({addr, rw}, ack);
        checkOutput("addr_ack", ack, matched ? I2C_ACK : I2C_NACK);
        checkOutput("busy_addressed", busy, matched);
        if (kind == KIND_PARTIAL) begin
            for (int i = 7; i >= 4; i--) send_bit(first[i]);
        end else if (!rw) begin
            for (int i = 0; i < n; i++) begin
                if (matched) exp_rx_q.push_back(payload[i]);
                send_byte(payload[i], ack);
                checkOutput("data_ack", ack, matched ? I2C_ACK : I2C_NACK);
            end
        end else begin
            for (int i = 0; i < n; i++) begin
                recv_byte(got);
                checkOutput("tx_byte", got, matched ? payload[i] : 8'hFF);
                if (i != n - 1 && matched) begin
                    tx_data_drv = payload[i + 1];
                    exp_tx_q.push_back(i + 1);
                end
                send_bit((i == n - 1) ? I2C_NACK : I2C_ACK);
            end
            checkOutput("sda_released_nack", sda_oe, 0);
        end
    endtask

    task automatic finishTransaction();
        send_stop();
        wait_clks(8);
        checkOutput("busy_after_stop", busy, 0);
        checkOutput("sda_oe_after_stop", sda_oe, 0);
        checkOutput("rx_pending", exp_rx_q.size(), 0);
        checkOutput("tx_pending", exp_tx_q.size(), 0);
        oe_allowed = 1'b0;
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         kind;
        int         n;
        logic [6:0] addr;
        logic [7:0] addr_w;

        reset       = 1'b1;
        oe_allowed  = 1'b0;
        tx_data_drv = 8'h00;
        wait_clks(5);
        checkOutput("reset_sda_oe", sda_oe, 0);
        checkOutput("reset_rx_data", rx_data, 8'h00);
        checkOutput("reset_rx_valid", rx_valid, 0);
        checkOutput("reset_tx_load", tx_load, 0);
        checkOutput("reset_busy", busy, 0);
        reset = 1'b0;
        wait_clks(5);

        $display("[TB] write 0x42: A5 3C");
        payload[0] = 8'hA5; payload[1] = 8'h3C;
        applyStimulus(KIND_WRITE, TGT_ADDR, 2);
        finishTransaction();

        $display("[TB] write to non-matching 0x43");
        payload[0] = 8'hFF;
        applyStimulus(KIND_WRITE, 7'h43, 1);
        finishTransaction();

        $display("[TB] read 0x42: 96 5A");
        payload[0] = 8'h96; payload[1] = 8'h5A;
        applyStimulus(KIND_READ, TGT_ADDR, 2);
        finishTransaction();

        $display("[TB] write 11, repeated start, read");
        payload[0] = 8'h11;
        applyStimulus(KIND_WRITE, TGT_ADDR, 1);
        checkOutput("rx_data_hold", rx_data, 8'h11);
        payload[0] = 8'hC3;
        applyStimulus(KIND_READ, TGT_ADDR, 1);
        finishTransaction();

        $display("[TB] stop after partial byte");
        payload[0] = 8'hE7;
        applyStimulus(KIND_PARTIAL, TGT_ADDR, 1);
        finishTransaction();

        $display("[TB] reset during address ACK");
        oe_allowed = 1'b1;
        addr_w     = {TGT_ADDR, 1'b0};
        send_start();
        for (int i = 7; i >= 0; i--) send_bit(addr_w[i]);
        wait_clks(Q); master_sda = 1'b1;
        wait_clks(2);
        checkOutput("ack_driven", sda_oe, 1);
        reset = 1'b1;
        wait_clks(1);
        checkOutput("rst_sda_oe", sda_oe, 0);
        checkOutput("rst_rx_data", rx_data, 8'h00);
        checkOutput("rst_rx_valid", rx_valid, 0);
        checkOutput("rst_tx_load", tx_load, 0);
        checkOutput("rst_busy", busy, 0);
        reset = 1'b0;
        wait_clks(4);
        master_scl = 1'b1;
        wait_clks(8);
        oe_allowed = 1'b0;
        payload[0] = 8'h5C; payload[1] = 8'h81;
        applyStimulus(KIND_WRITE, TGT_ADDR, 2);
        finishTransaction();

        $display("[TB] randomized transactions");
        for (int k = 0; k < 16; k++) begin
            kind = int'($urandom_range(0, 2));
            n    = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) payload[i] = 8'($urandom);
            if (kind == 0) begin
                applyStimulus(KIND_WRITE, TGT_ADDR, n);
            end else if (kind == 1) begin
                applyStimulus(KIND_READ, TGT_ADDR, n);
            end else begin
                addr = 7'($urandom_range(0, 127));
                applyStimulus(KIND_WRITE, addr, n);
            end
            finishTransaction();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
